prog_code_detonator: RTL

Parametrised next-generation numeric code detonator controller.
- Accepts a configurable number of decimal digits from a synchronous keypad pulse bus and compares them against a stored code.
- The stored code is re-programmable after a successful unlock.
- Adds an entry timeout and a retry limit with timed lockout.
- Sits between the debounced keypad/switch front end and the LED, buzzer and 7-seg display drivers.

---
 rtl/ncd_pkg.sv | 38 +++
 rtl/ncd_blink_gen.sv | 46 ++++
 rtl/prog_code_detonator.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ncd_pkg
// Purpose  : Shared definitions for the numeric code detonator controller:
//            FSM state encodings, BCD digit width and the keypad priority
//            encoder used to turn a one-hot-ish key pulse bus into a digit.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package ncd_pkg;

    localparam int c_bcd_w = 4;

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_armed   = 4'd1;
    localparam logic [3:0] c_st_entry   = 4'd2;
    localparam logic [3:0] c_st_verify  = 4'd3;
    localparam logic [3:0] c_st_ok      = 4'd4;
    localparam logic [3:0] c_st_fire    = 4'd5;
    localparam logic [3:0] c_st_prog    = 4'd6;
    localparam logic [3:0] c_st_error   = 4'd7;
    localparam logic [3:0] c_st_lockout = 4'd8;

    // Lowest set key index wins: scanning downwards lets the last hit
    // (the lowest index) overwrite any higher one.
    function automatic logic [c_bcd_w-1:0] key_to_bcd(input logic [9:0] key);
        logic [c_bcd_w-1:0] w_digit;
        w_digit = '0;
        for (int i = 9; i >= 0; i--) begin
            if (key[i]) begin
                w_digit = c_bcd_w'(i);
            end
        end
        return w_digit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ncd_blink_gen.sv
`default_nettype none
// ============================================================================
// Module   : ncd_blink_gen
// Purpose  : Free-running blink source. While en is high a counter runs from
//            0 to MAX and toggles the blink bit on each wrap, giving a square
//            wave of half-period MAX+1 cycles that starts low. Dropping en
//            clears both the counter and the blink bit.
// Ports    : clk   - system clock
//            rst   - asynchronous, active-low reset
//            en    - run enable
//            blink - blink output
// Revision : 1.0 - initial release
// ============================================================================
module ncd_blink_gen #(
    parameter int MAX = 12499
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic blink
);

    localparam int c_cnt_w = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_blink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (r_cnt == c_cnt_w'(MAX)) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + c_cnt_w'(1);
        end
    end

    assign blink = r_blink;

endmodule
`default_nettype wire

// File: rtl/prog_code_detonator.sv
`default_nettype none
// ============================================================================
// Module   : prog_code_detonator
// Purpose  : Programmable numeric code detonator controller. Collects DIGITS
//            BCD digits from the keypad, verifies them against a stored code
//            (re-programmable after unlock), with entry timeout, retry limit
//            and timed lockout. Outputs drive LEDs, buzzer and 7-seg display.
// Ports    : clk       - system clock
//            rst       - asynchronous, active-low reset
//            key[9:0]  - one-cycle key pulses, lowest set bit taken
//            ready     - arm request
//            wait_t    - abort to IDLE
//            sure      - confirm entry
//            fire      - fire request
//            setup     - clear ERROR
//            prog      - enter code programming from OK
//            lt        - green LED, state OK
//            bt        - yellow LED, state FIRE
//            rt        - red LED, blinks in ERROR, steady in LOCKOUT
//            lb        - buzzer, steady in ERROR, blinks in LOCKOUT
//            m_disp    - last accepted digit
//            fail_cnt  - consecutive failed verifies
//            prog_done - one-cycle pulse when a new code is stored
// Revision : 1.0 - initial release
// ============================================================================
module prog_code_detonator
    import ncd_pkg::*;
#(
    parameter int                 DIGITS       = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h2580,
    parameter int                 MAX_TRIES    = 3,
    parameter int                 BLINK_MAX    = 12499,
    parameter int                 TIMEOUT_MAX  = 1000000,
    parameter int                 LOCK_MAX     = 4000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     key,
    input  logic                           ready,
    input  logic                           wait_t,
    input  logic                           sure,
    input  logic                           fire,
    input  logic                           setup,
    input  logic                           prog,
    output logic                           lt,
    output logic                           bt,
    output logic                           rt,
    output logic                           lb,
    output logic [3:0]                     m_disp,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
    output logic                           prog_done
);

    localparam int c_code_w = c_bcd_w * DIGITS;
    localparam int c_cnt_w  = $clog2(DIGITS + 1);
    localparam int c_fail_w = $clog2(MAX_TRIES + 1);
    localparam int c_tmo_w  = (TIMEOUT_MAX > 0) ? $clog2(TIMEOUT_MAX + 1) : 1;
    localparam int c_lock_w = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;

    // Registered state
    logic [3:0]          r_state;
    logic [c_code_w-1:0] r_code;
    logic [c_code_w-1:0] r_buf;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_fail_w-1:0] r_fail;
    logic [3:0]          r_disp;
    logic                r_prog_done;
    logic [c_tmo_w-1:0]  r_tmo;
    logic [c_lock_w-1:0] r_lock;

    // Next-state values
    logic [3:0]          w_state_nxt;
    logic [c_code_w-1:0] w_code_nxt;
    logic [c_code_w-1:0] w_buf_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_fail_w-1:0] w_fail_nxt;
    logic [3:0]          w_disp_nxt;
    logic                w_prog_done_nxt;
    logic [c_tmo_w-1:0]  w_tmo_nxt;
    logic [c_lock_w-1:0] w_lock_nxt;

    // Helpers
    logic                    w_key_any;
    logic [c_bcd_w-1:0]      w_digit;
    logic [c_code_w+3:0]     w_cat;
    logic                    w_full;
    logic [c_fail_w-1:0]     w_fail_inc;
    logic                    w_blink_err;
    logic                    w_blink_lock;

    assign w_key_any  = |key;
    assign w_digit    = key_to_bcd(key);
    assign w_cat      = {r_buf, w_digit};
    assign w_full     = (r_cnt == c_cnt_w'(DIGITS));
    assign w_fail_inc = r_fail + c_fail_w'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_code      <= DEFAULT_CODE;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_fail      <= '0;
            r_disp      <= '0;
            r_prog_done <= 1'b0;
            r_tmo       <= '0;
            r_lock      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fail      <= w_fail_nxt;
            r_disp      <= w_disp_nxt;
            r_prog_done <= w_prog_done_nxt;
            r_tmo       <= w_tmo_nxt;
            r_lock      <= w_lock_nxt;
        end
    end

    // Next-state logic. The timeout and lock counters default to zero and are
    // only advanced on paths that stay in the same state, so any transition
    // (or accepted key, for the timeout) restarts them.
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_buf_nxt       = r_buf;
        w_cnt_nxt       = r_cnt;
        w_fail_nxt      = r_fail;
        w_disp_nxt      = r_disp;
        w_prog_done_nxt = 1'b0;
        w_tmo_nxt       = '0;
        w_lock_nxt      = '0;

        case (r_state)
            c_st_idle: begin
                if (fire) begin
                    w_state_nxt = c_st_error;
                end else if (ready) begin
                    w_state_nxt = c_st_armed;
                end
            end

            c_st_armed: begin
                if (sure || fire) begin
                    w_state_nxt = c_st_error;
                end else if (wait_t) begin
                    w_state_nxt = c_st_idle;
                end else if (w_key_any) begin
                    w_state_nxt = c_st_entry;
                    w_buf_nxt   = c_code_w'(w_digit);
                    w_cnt_nxt   = c_cnt_w'(1);
                    w_disp_nxt  = w_digit;
                end
            end

            // ENTRY and PROG share the digit collection rules; they differ
            // only in fire handling and in what a complete sure does.
            c_st_entry, c_st_prog: begin
                if ((r_state == c_st_entry) && fire) begin
                    w_state_nxt = c_st_error;
                end else if (sure) begin
                    if (!w_full) begin
                        w_state_nxt = c_st_error;
                    end else if (r_state == c_st_entry) begin
                        w_state_nxt = c_st_verify;
                    end else begin
                        w_code_nxt      = r_buf;
                        w_prog_done_nxt = 1'b1;
                        w_state_nxt     = c_st_idle;
                    end
                end else if (wait_t) begin
                    w_state_nxt = c_st_idle;
                end else if (w_key_any) begin
                    if (w_full) begin
                        w_state_nxt = c_st_error;
                    end else begin
                        w_buf_nxt  = w_cat[c_code_w-1:0];
                        w_cnt_nxt  = r_cnt + c_cnt_w'(1);
                        w_disp_nxt = w_digit;
                    end
                end else if (r_tmo == c_tmo_w'(TIMEOUT_MAX)) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_tmo_nxt = r_tmo + c_tmo_w'(1);
                end
            end

            c_st_verify: begin
                if (r_buf == r_code) begin
                    w_state_nxt = c_st_ok;
                    w_fail_nxt  = '0;
                end else begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = (w_fail_inc == c_fail_w'(MAX_TRIES)) ?
                                  c_st_lockout : c_st_error;
                end
            end

            c_st_ok: begin
                if (fire) begin
                    w_state_nxt = c_st_fire;
                end else if (prog) begin
                    w_state_nxt = c_st_prog;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (wait_t) begin
                    w_state_nxt = c_st_idle;
                end
            end

            c_st_fire: begin
                w_state_nxt = c_st_idle;
            end

            c_st_error: begin
                if (setup) begin
                    w_state_nxt = c_st_idle;
                end
            end

            c_st_lockout: begin
                if (r_lock == c_lock_w'(LOCK_MAX)) begin
                    w_state_nxt = c_st_error;
                    w_fail_nxt  = '0;
                end else begin
                    w_lock_nxt = r_lock + c_lock_w'(1);
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Separate blink sources per state so that each starts low on entry,
    // including the direct LOCKOUT -> ERROR hand-over.
    ncd_blink_gen #(
        .MAX   (BLINK_MAX)
    ) u_blink_err (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state == c_st_error),
        .blink (w_blink_err)
    );

    ncd_blink_gen #(
        .MAX   (BLINK_MAX)
    ) u_blink_lock (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state == c_st_lockout),
        .blink (w_blink_lock)
    );

    // Output decode from current state
    assign lt        = (r_state == c_st_ok);
    assign bt        = (r_state == c_st_fire);
    assign rt        = (r_state == c_st_error)   ? w_blink_err :
                       (r_state == c_st_lockout);
    assign lb        = (r_state == c_st_error) ||
                       ((r_state == c_st_lockout) && w_blink_lock);
    assign m_disp    = r_disp;
    assign fail_cnt  = r_fail;
    assign prog_done = r_prog_done;

endmodule
`default_nettype wire
